// File: rtl/new_means_divider_seq.sv
// Centroid update sequencer: for each cluster, divides the 7 coordinate sums by the point count
// with 7 parallel restoring dividers and presents the saturated quotient with a valid strobe.
module new_means_divider_seq #(
  parameter int unsigned centroid_num     = 8,
  parameter int unsigned accum_cord_width = 22,
  parameter int unsigned accum_width      = 7 * 22,
  parameter int unsigned cordinate_width  = 13,
  parameter int unsigned dataWidth        = 91,
  parameter int unsigned count_width      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   conv_clear_n,
  output logic [2:0]             acc_rd_addr,
  input  logic [accum_width-1:0] acc_rd_data,
  input  logic [count_width-1:0] cnt_rd_data,
  output logic [dataWidth-1:0]   new_centroid,
  output logic [2:0]             cent_num,
  output logic                   divide_by_0,
  output logic                   convergence_reg_en
);

  localparam int unsigned NCoord = 7;
  localparam int unsigned AW     = accum_cord_width;
  localparam int unsigned CW     = cordinate_width;
  localparam int unsigned IW     = $clog2(AW + 1);

  localparam logic [AW-1:0] PosMax = AW'((1 << (CW - 1)) - 1);
  localparam logic [AW-1:0] NegMag = AW'(1 << (CW - 1));
  localparam logic [2:0]    LastIdx = 3'(centroid_num - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StDiv, StPresent, StDone} state_e;

  state_e                               state_q, state_d;
  logic [2:0]                           idx_q, idx_d;
  logic [IW-1:0]                        iter_q, iter_d;
  logic [count_width-1:0]               divisor_q, divisor_d;
  logic [NCoord-1:0]                    sign_q, sign_d;
  logic [NCoord-1:0][count_width-1:0]   rem_q, rem_d;
  logic [NCoord-1:0][AW-1:0]            quo_q, quo_d;
  logic [dataWidth-1:0]                 cent_q, cent_d;
  logic [2:0]                           num_q, num_d;
  logic                                 dz_q, dz_d;
  logic                                 clr_n_q, clr_n_d;

  logic [NCoord-1:0][count_width:0]     trial, diff;
  logic [NCoord-1:0][count_width-1:0]   step_rem;
  logic [NCoord-1:0][AW-1:0]            step_quo;
  logic [NCoord-1:0][AW-1:0]            acc_coord;

  // Magnitude in, sign applied afterwards; bounds are asymmetric for two's complement.
  function automatic logic [CW-1:0] saturate(input logic neg, input logic [AW-1:0] mag);
    logic [CW-1:0] res;
    if (!neg) res = (mag > PosMax) ? PosMax[CW-1:0] : mag[CW-1:0];
    else      res = (mag > NegMag) ? NegMag[CW-1:0] : CW'(0) - mag[CW-1:0];
    return res;
  endfunction

  // One restoring step per lane: shift the next dividend bit into the remainder.
  always_comb begin
    for (int k = 0; k < NCoord; k++) begin
      acc_coord[k] = acc_rd_data[k*AW +: AW];
      trial[k]     = {rem_q[k], quo_q[k][AW-1]};
      diff[k]      = trial[k] - {1'b0, divisor_q};
      if (trial[k] >= {1'b0, divisor_q}) begin
        step_rem[k] = diff[k][count_width-1:0];
        step_quo[k] = {quo_q[k][AW-2:0], 1'b1};
      end else begin
        step_rem[k] = trial[k][count_width-1:0];
        step_quo[k] = {quo_q[k][AW-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    iter_d    = iter_q;
    divisor_d = divisor_q;
    sign_d    = sign_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cent_d    = cent_q;
    num_d     = num_q;
    dz_d      = dz_q;
    clr_n_d   = 1'b1;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = 3'd0;
          num_d   = 3'd0;
          clr_n_d = 1'b0;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        divisor_d = cnt_rd_data;
        if (cnt_rd_data == '0) begin
          state_d = StPresent;
          cent_d  = '0;
          dz_d    = 1'b1;
          num_d   = idx_q;
        end else begin
          state_d = StDiv;
          iter_d  = IW'(AW);
          for (int k = 0; k < NCoord; k++) begin
            sign_d[k] = acc_coord[k][AW-1];
            quo_d[k]  = acc_coord[k][AW-1] ? AW'(0) - acc_coord[k] : acc_coord[k];
            rem_d[k]  = '0;
          end
        end
      end
      StDiv: begin
        rem_d  = step_rem;
        quo_d  = step_quo;
        iter_d = iter_q - IW'(1);
        if (iter_q == IW'(1)) begin
          state_d = StPresent;
          dz_d    = 1'b0;
          num_d   = idx_q;
          for (int k = 0; k < NCoord; k++) begin
            cent_d[k*CW +: CW] = saturate(sign_q[k], step_quo[k]);
          end
        end
      end
      StPresent: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      iter_q    <= '0;
      divisor_q <= '0;
      sign_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cent_q    <= '0;
      num_q     <= '0;
      dz_q      <= 1'b0;
      clr_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      iter_q    <= iter_d;
      divisor_q <= divisor_d;
      sign_q    <= sign_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cent_q    <= cent_d;
      num_q     <= num_d;
      dz_q      <= dz_d;
      clr_n_q   <= clr_n_d;
    end
  end

  assign busy               = (state_q != StIdle);
  assign done               = (state_q == StDone);
  assign convergence_reg_en = (state_q == StPresent);
  assign conv_clear_n       = clr_n_q;
  assign acc_rd_addr        = idx_q;
  assign new_centroid       = cent_q;
  assign cent_num           = num_q;
  assign divide_by_0        = dz_q;

endmodule

// File: tb/tb_new_means_divider_seq.sv
// Scoreboard bench for new_means_divider_seq: expected strobes are queued at start, popped on
// each convergence_reg_en and compared for timing, index, divide-by-zero flag and quotient word.
module tb_new_means_divider_seq;

  localparam int AW = 22;
  localparam int CW = 13;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy, done, conv_clear_n;
  logic [2:0]   acc_rd_addr;
  logic [153:0] acc_rd_data;
  logic [9:0]   cnt_rd_data;
  logic [90:0]  new_centroid;
  logic [2:0]   cent_num;
  logic         divide_by_0, convergence_reg_en;

  always #5 clk = ~clk;

  new_means_divider_seq dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .conv_clear_n      (conv_clear_n),
    .acc_rd_addr       (acc_rd_addr),
    .acc_rd_data       (acc_rd_data),
    .cnt_rd_data       (cnt_rd_data),
    .new_centroid      (new_centroid),
    .cent_num          (cent_num),
    .divide_by_0       (divide_by_0),
    .convergence_reg_en(convergence_reg_en)
  );

  // Accumulator bank with one-cycle registered read.
  logic [153:0] acc_mem [8];
  logic [9:0]   cnt_mem [8];
  always @(posedge clk) begin
    acc_rd_data <= acc_mem[acc_rd_addr];
    cnt_rd_data <= cnt_mem[acc_rd_addr];
  end

  int acc_val [8][7];
  int cnt_val [8];
  int basic   [7] = '{100, -100, 0, 7, -7, 4095, -4095};

  typedef struct {
    int          cyc;
    logic [2:0]  num;
    logic        dz;
    logic [90:0] word;
  } exp_t;

  exp_t sb_q[$];
  int   done_q[$];
  exp_t mon_e;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   clr_seen = 0;
  int   clr_exp  = 0;
  logic prev_en  = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [CW-1:0] exp_coord(input int a, input int c);
    int q;
    q = a / c;
    if (q > 4095)  q = 4095;
    if (q < -4096) q = -4096;
    return q[CW-1:0];
  endfunction

  task automatic commit();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 7; k++) acc_mem[i][k*AW +: AW] = acc_val[i][k][AW-1:0];
      cnt_mem[i] = cnt_val[i][9:0];
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 7; k++) acc_val[i][k] = basic[k];
      cnt_val[i] = 1;
    end
    commit();
  endtask

  task automatic push_pass(input int fetch);
    int t;
    t = fetch;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      int   lat;
      lat    = (cnt_val[i] == 0) ? 3 : 25;
      e.cyc  = t + lat - 1;
      e.num  = i[2:0];
      e.dz   = (cnt_val[i] == 0);
      e.word = '0;
      if (!e.dz) begin
        for (int k = 0; k < 7; k++) e.word[k*CW +: CW] = exp_coord(acc_val[i][k], cnt_val[i]);
      end
      sb_q.push_back(e);
      t += lat;
    end
    done_q.push_back(t);
    clr_exp++;
  endtask

  task automatic start_pass(output int fetch);
    @(negedge clk);
    start = 1'b1;
    fetch = cyc + 1;
    push_pass(fetch);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!conv_clear_n) begin
          clr_seen++;
          check("clr_cent_num", cent_num, 0);
        end
        if (convergence_reg_en) begin
          check("en_gap", prev_en, 0);
          if (sb_q.size() == 0) begin
            check("unexp_strobe", convergence_reg_en, 0);
          end else begin
            mon_e = sb_q.pop_front();
            check("strobe_cyc", cyc, mon_e.cyc);
            check("cent_num", cent_num, mon_e.num);
            check("divide_by_0", divide_by_0, mon_e.dz);
            check("centroid", new_centroid, mon_e.word);
          end
        end
        if (done) begin
          if (done_q.size() == 0) check("unexp_done", done, 0);
          else check("done_cyc", cyc, done_q.pop_front());
        end
      end
      prev_en = convergence_reg_en;
    end
  end

  initial begin
    int          f;
    logic [90:0] hold_word;

    rst_n = 1'b0;
    start = 1'b0;
    load_basic();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clr_n", conv_clear_n, 1);
    check("rst_en", convergence_reg_en, 0);
    check("rst_cent_num", cent_num, 0);
    check("rst_dz", divide_by_0, 0);
    check("rst_centroid", new_centroid, 0);
    check("rst_addr", acc_rd_addr, 0);
    rst_n = 1'b1;

    // Basic pass, then output hold after completion.
    start_pass(f);
    wait_until(f + 203);
    hold_word = '0;
    for (int k = 0; k < 7; k++) hold_word[k*CW +: CW] = exp_coord(basic[k], 1);
    check("hold_cent_num", cent_num, 7);
    check("hold_centroid", new_centroid, hold_word);
    check("idle_busy", busy, 0);

    // Truncation, sign, saturation, divide-by-zero on cluster 5, random clusters.
    acc_val[0] = '{25, -25, 0, 1, -1, 3, -3};
    cnt_val[0] = 4;
    acc_val[1] = '{3, -3, 9, -9, 10, -10, 2097151};
    cnt_val[1] = 10;
    acc_val[2] = '{2097151, -2097152, 4096, -4097, 4095, -4096, 0};
    cnt_val[2] = 1;
    for (int i = 3; i < 8; i++) begin
      for (int k = 0; k < 7; k++) begin
        int r;
        r = $urandom;
        acc_val[i][k] = (r <<< 10) >>> 10;
      end
      cnt_val[i] = (i == 5) ? 0 : int'($urandom_range(1, 1023));
    end
    commit();
    start_pass(f);
    wait_until(f + 7 * 25 + 3 + 3);

    // Start held high through a whole pass: restart only after DONE and IDLE.
    load_basic();
    @(negedge clk);
    start = 1'b1;
    f = cyc + 1;
    push_pass(f);
    push_pass(f + 202);
    wait_until(f + 202);
    start = 1'b0;
    wait_until(f + 402 + 3);

    // Reset in the middle of dividing centroid 3.
    start_pass(f);
    wait_until(f + 3 * 25 + 10);
    rst_n = 1'b0;
    sb_q.delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_en", convergence_reg_en, 0);
    check("abort_cent_num", cent_num, 0);
    check("abort_done", done, 0);
    repeat (30) @(negedge clk);
    start_pass(f);
    wait_until(f + 203);

    check("sb_empty", sb_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("clr_count", clr_seen, clr_exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
